wb_sram: RTL and testbench

WB_SRAM -- requirements
Module: wb_sram

---
 rtl/wb_sram.sv | 130 +++++++++++++
 tb/tb_wb_sram.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/wb_sram.sv
// Wishbone B4 single-port SRAM slave with byte lanes, optional first-beat wait states,
// classic/constant/incrementing burst support and ERR on out-of-range word index.
module wb_sram #(
   parameter int unsigned DEPTH         = 4096,
   parameter int unsigned WB_ADDR_WIDTH = 32,
   parameter int unsigned WB_DATA_WIDTH = 32,
   parameter int unsigned WAIT_STATES   = 0,
   parameter int unsigned SEL_WIDTH     = WB_DATA_WIDTH / 8
) (
   input  logic                     WB_CLK_I,
   input  logic                     WB_RST_I,
   input  logic [WB_ADDR_WIDTH-1:0] WB_ADR_I,
   input  logic [WB_DATA_WIDTH-1:0] WB_DAT_I,
   output logic [WB_DATA_WIDTH-1:0] WB_DAT_O,
   input  logic [SEL_WIDTH-1:0]     WB_SEL_I,
   input  logic                     WB_WE_I,
   input  logic [2:0]               WB_CTI_I,
   input  logic                     WB_CYC_I,
   input  logic                     WB_STB_I,
   output logic                     WB_ACK_O,
   output logic                     WB_ERR_O,
   output logic                     WB_RTY_O,
   output logic                     WB_STALL_O
);

   localparam int unsigned LSB = $clog2(SEL_WIDTH);
   localparam int unsigned IW  = WB_ADDR_WIDTH - LSB;
   localparam int unsigned MW  = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, BURST, END} state_t;

   state_t                   state, nxt;
   logic [2:0]               cnt, cnt_next;
   logic                     stall_next;
   logic                     access;
   logic                     go;
   logic                     burst_cti;
   logic                     in_range;
   logic [IW-1:0]            index;
   logic [MW-1:0]            addr;
   logic [WB_DATA_WIDTH-1:0] mem [DEPTH];
   logic                     unused_lsb;

   assign index      = WB_ADR_I[WB_ADDR_WIDTH-1:LSB];
   assign addr       = index[MW-1:0];
   assign in_range   = (index >> MW) == '0;
   assign go         = WB_CYC_I & WB_STB_I;
   assign burst_cti  = (WB_CTI_I == 3'b001) || (WB_CTI_I == 3'b010);
   assign unused_lsb = ^WB_ADR_I[LSB-1:0];
   assign WB_RTY_O   = 1'b0;

   always_ff @(posedge WB_CLK_I) begin
      if (WB_RST_I) state <= IDLE;
      else          state <= nxt;
   end

   // access marks the edge on which ADR/DAT/SEL/WE are sampled; ACK/ERR follow one cycle later
   always_comb begin
      nxt    = state;
      access = 1'b0;
      unique case (state)
         IDLE: begin
            if (go) begin
               if (WAIT_STATES == 0) begin
                  access = 1'b1;
                  nxt    = burst_cti ? BURST : END;
               end else begin
                  nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (!WB_CYC_I) begin
               nxt = IDLE;
            end else if (cnt == 3'd1) begin
               access = 1'b1;
               nxt    = burst_cti ? BURST : END;
            end
         end
         BURST: begin
            if (!WB_CYC_I) begin
               nxt = IDLE;
            end else if (WB_STB_I) begin
               access = 1'b1;
               if (WB_CTI_I == 3'b111) nxt = END;
            end
         end
         END:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      cnt_next   = '0;
      stall_next = 1'b0;
      if (state == IDLE && go && WAIT_STATES != 0) begin
         cnt_next   = 3'(WAIT_STATES);
         stall_next = 1'b1;
      end else if (state == WAIT && WB_CYC_I && cnt != 3'd1) begin
         cnt_next   = cnt - 3'd1;
         stall_next = 1'b1;
      end
   end

   always_ff @(posedge WB_CLK_I) begin
      if (WB_RST_I) begin
         cnt        <= '0;
         WB_ACK_O   <= 1'b0;
         WB_ERR_O   <= 1'b0;
         WB_STALL_O <= 1'b0;
         WB_DAT_O   <= '0;
      end else begin
         cnt        <= cnt_next;
         WB_ACK_O   <= access & in_range;
         WB_ERR_O   <= access & ~in_range;
         WB_STALL_O <= stall_next;
         if (access && in_range && !WB_WE_I) WB_DAT_O <= mem[addr];
      end
   end

   // memory is deliberately outside the reset domain so contents survive reset
   always_ff @(posedge WB_CLK_I) begin
      if (!WB_RST_I && access && in_range && WB_WE_I) begin
         for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
            if (WB_SEL_I[i]) mem[addr][8*i +: 8] <= WB_DAT_I[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wb_sram.sv
// Directed bench for wb_sram: one instance with no wait states, one with three.
module tb_wb_sram;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] adr, dat_i;
   logic [3:0]  sel;
   logic        we;
   logic [2:0]  cti;
   logic        stb;
   logic        cyc0, cyc3;
   logic [31:0] dat0, dat3;
   logic        ack0, err0, rty0, stall0;
   logic        ack3, err3, rty3, stall3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_sram #(.DEPTH(4096), .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
      .WB_CLK_I(clk), .WB_RST_I(rst), .WB_ADR_I(adr), .WB_DAT_I(dat_i), .WB_DAT_O(dat0),
      .WB_SEL_I(sel), .WB_WE_I(we), .WB_CTI_I(cti), .WB_CYC_I(cyc0), .WB_STB_I(stb),
      .WB_ACK_O(ack0), .WB_ERR_O(err0), .WB_RTY_O(rty0), .WB_STALL_O(stall0)
   );

   wb_sram #(.DEPTH(4096), .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .WAIT_STATES(3)) dut3 (
      .WB_CLK_I(clk), .WB_RST_I(rst), .WB_ADR_I(adr), .WB_DAT_I(dat_i), .WB_DAT_O(dat3),
      .WB_SEL_I(sel), .WB_WE_I(we), .WB_CTI_I(cti), .WB_CYC_I(cyc3), .WB_STB_I(stb),
      .WB_ACK_O(ack3), .WB_ERR_O(err3), .WB_RTY_O(rty3), .WB_STALL_O(stall3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // classic cycle on dut0, entered and left at a falling edge
   task automatic bus0(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic exp_err, input logic [31:0] exp_dat);
      adr = a; dat_i = d; sel = s; we = w; cti = 3'b000; cyc0 = 1'b1; stb = 1'b1;
      @(negedge clk);
      check({tag, "_ack"}, {31'd0, ack0}, {31'd0, ~exp_err});
      check({tag, "_err"}, {31'd0, err0}, {31'd0, exp_err});
      if (!w) check({tag, "_dat"}, dat0, exp_dat);
      cyc0 = 1'b0; stb = 1'b0;
      @(negedge clk);
      check({tag, "_ack_low"}, {31'd0, ack0 | err0}, 32'd0);
   endtask

   // classic cycle on dut3: three stall cycles, then ACK on the fourth cycle after STB
   task automatic bus3(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_dat);
      adr = a; dat_i = d; sel = 4'hF; we = w; cti = 3'b000; cyc3 = 1'b1; stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check({tag, "_stall"}, {30'd0, stall3, ack3}, 32'd2);
      end
      @(negedge clk);
      check({tag, "_ack"}, {30'd0, stall3, ack3}, 32'd1);
      if (!w) check({tag, "_dat"}, dat3, exp_dat);
      cyc3 = 1'b0; stb = 1'b0;
      @(negedge clk);
      check({tag, "_ack_low"}, {31'd0, ack3}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; adr = '0; dat_i = '0; sel = '0; we = 1'b0; cti = '0;
      stb = 1'b0; cyc0 = 1'b0; cyc3 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_outs0", {28'd0, ack0, err0, rty0, stall0}, 32'd0);
      check("rst_outs3", {28'd0, ack3, err3, rty3, stall3}, 32'd0);
      check("rst_dat0", dat0, 32'd0);
      rst = 1'b0;

      bus0("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
      bus0("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
      bus0("wr_lane", 1'b1, 32'h10, 32'h00000055, 4'h1, 1'b0, 32'h0);
      bus0("rd_lane", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBE55);
      bus0("wr_sel0", 1'b1, 32'h10, 32'h12345678, 4'h0, 1'b0, 32'h0);
      bus0("rd_sel0", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBE55);
      bus0("rd_oor", 1'b0, 32'h4000, 32'h0, 4'hF, 1'b1, 32'hDEADBE55);
      bus0("wr_oor", 1'b1, 32'h4010, 32'h00000BAD, 4'hF, 1'b1, 32'h0);
      bus0("rd_alias", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBE55);

      // incrementing write burst 0x0, 0x4, 0x8
      adr = 32'h0; dat_i = 32'h11111111; sel = 4'hF; we = 1'b1; cti = 3'b010; cyc0 = 1'b1; stb = 1'b1;
      @(negedge clk); check("bw_ack0", {31'd0, ack0}, 32'd1);
      adr = 32'h4; dat_i = 32'h22222222;
      @(negedge clk); check("bw_ack1", {31'd0, ack0}, 32'd1);
      adr = 32'h8; dat_i = 32'h33333333; cti = 3'b111;
      @(negedge clk); check("bw_ack2", {31'd0, ack0}, 32'd1);
      cyc0 = 1'b0; stb = 1'b0; cti = 3'b000;
      @(negedge clk); check("bw_end", {31'd0, ack0}, 32'd0);
      bus0("rb0", 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h11111111);
      bus0("rb4", 1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h22222222);
      bus0("rb8", 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h33333333);

      // read burst with an STB gap
      adr = 32'h4; we = 1'b0; cti = 3'b010; cyc0 = 1'b1; stb = 1'b1;
      @(negedge clk); check("br_dat0", dat0, 32'h22222222); check("br_ack0", {31'd0, ack0}, 32'd1);
      stb = 1'b0;
      @(negedge clk); check("br_gap", {31'd0, ack0}, 32'd0);
      adr = 32'h8; cti = 3'b111; stb = 1'b1;
      @(negedge clk); check("br_dat1", dat0, 32'h33333333); check("br_ack1", {31'd0, ack0}, 32'd1);
      cyc0 = 1'b0; stb = 1'b0; cti = 3'b000;
      @(negedge clk); check("br_end", {31'd0, ack0}, 32'd0);

      // reset while a burst write is in flight
      bus0("wr24", 1'b1, 32'h24, 32'h24242424, 4'hF, 1'b0, 32'h0);
      adr = 32'h20; dat_i = 32'hAAAAAAAA; sel = 4'hF; we = 1'b1; cti = 3'b010; cyc0 = 1'b1; stb = 1'b1;
      @(negedge clk); check("rb_ack", {31'd0, ack0}, 32'd1);
      adr = 32'h24; dat_i = 32'hBBBBBBBB; rst = 1'b1;
      @(negedge clk);
      check("rb_outs", {28'd0, ack0, err0, rty0, stall0}, 32'd0);
      check("rb_dat", dat0, 32'd0);
      rst = 1'b0; cyc0 = 1'b0; stb = 1'b0; cti = 3'b000;
      @(negedge clk);
      bus0("rd24", 1'b0, 32'h24, 32'h0, 4'hF, 1'b0, 32'h24242424);
      bus0("rd20", 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'hAAAAAAAA);
      bus0("rd10_keep", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBE55);

      // three wait states, plus an aborted write
      bus3("ws_wr", 1'b1, 32'h40, 32'hCAFEF00D, 32'h0);
      bus3("ws_rd", 1'b0, 32'h40, 32'h0, 32'hCAFEF00D);
      adr = 32'h40; dat_i = 32'h0BADBAD0; we = 1'b1; cyc3 = 1'b1; stb = 1'b1;
      @(negedge clk); check("ab_stall", {31'd0, stall3}, 32'd1);
      cyc3 = 1'b0; stb = 1'b0;
      @(negedge clk); check("ab_drop", {30'd0, stall3, ack3}, 32'd0);
      repeat (3) begin
         @(negedge clk); check("ab_quiet", {30'd0, ack3, err3}, 32'd0);
      end
      bus3("ab_rd", 1'b0, 32'h40, 32'h0, 32'hCAFEF00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
